// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: mul/div sequencer states,
// EX-stage forward selects and the forwarding-source decode.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    MD_HOLD = 2'd2
  } md_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hard-wired to zero, so a write to it must never be forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [2:0] wr_m,
    input logic [4:0] rd_w,
    input logic [2:0] wr_w
  );
    if ((|wr_m) && (rd_m != 5'd0) && (rd_m == rs))      return FWD_MEM;
    else if ((|wr_w) && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
    else                                                return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with enable; holds at all-ones once reached.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the five-stage pipeline, including the
// mul/div start/done sequencer. Define HAZARD_PERF_CNT_EN to build the counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CpuClk,
  input  logic             CpuRstN,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [1:0]       RegReadD,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             MemToRegE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [2:0]       RegWriteM,
  input  logic [2:0]       RegWriteW,
  input  logic             BranchE,
  input  logic             JalrE,
  input  logic             JalD,
  input  logic             MulDivE,
  input  logic             MdDone,
  input  logic             ICacheMiss,
  input  logic             DCacheMiss,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       Forward1E,
  output logic [1:0]       Forward2E,
  output logic             MdStart,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  md_state_e state_q, state_d;
  logic miss, br_taken, load_use, md_front;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m;
  logic md_start;

  assign miss     = ICacheMiss | DCacheMiss;
  assign br_taken = BranchE | JalrE;
  assign load_use = MemToRegE && (RdE != 5'd0) &&
                    ((RegReadD[1] && (RdE == Rs1D)) || (RegReadD[0] && (RdE == Rs2D)));

  always_ff @(posedge CpuClk or negedge CpuRstN) begin
    if (!CpuRstN) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    md_front = 1'b0;
    md_start = 1'b0;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    stall_w  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;

    if (miss) begin
      // A miss freezes everything; a result arriving now is parked in MD_HOLD.
      {stall_f, stall_d, stall_e, stall_m, stall_w} = '1;
      if ((state_q == MD_BUSY) && MdDone) state_d = MD_HOLD;
    end else begin
      unique case (state_q)
        RUN: begin
          if (MulDivE) begin
            md_start = 1'b1;
            md_front = 1'b1;
            state_d  = MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (MdDone) state_d  = RUN;
          else        md_front = 1'b1;
        end
        MD_HOLD: state_d = RUN;
        default: state_d = RUN;
      endcase

      if (md_front) begin
        {stall_f, stall_d, stall_e} = '1;
        flush_m = 1'b1;
      end else if (br_taken) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (JalD) begin
        flush_d = 1'b1;
      end
    end
  end

  // Reset is applied combinationally so the pipeline sees bubbles immediately.
  assign StallF    = CpuRstN & stall_f;
  assign StallD    = CpuRstN & stall_d;
  assign StallE    = CpuRstN & stall_e;
  assign StallM    = CpuRstN & stall_m;
  assign StallW    = CpuRstN & stall_w;
  assign FlushF    = ~CpuRstN;
  assign FlushD    = ~CpuRstN | flush_d;
  assign FlushE    = ~CpuRstN | flush_e;
  assign FlushM    = ~CpuRstN | flush_m;
  assign FlushW    = ~CpuRstN;
  assign MdStart   = CpuRstN & md_start;
  assign Forward1E = CpuRstN ? fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW) : FWD_RF;
  assign Forward2E = CpuRstN ? fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW) : FWD_RF;

`ifdef HAZARD_PERF_CNT_EN
  // A branch flush is the only case raising FlushE without a front-end stall.
  logic br_flush;
  assign br_flush = br_taken & FlushE & ~StallF;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (CpuClk),
    .rst_n(CpuRstN),
    .en_i (StallF),
    .cnt_o(StallCnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk  (CpuClk),
    .rst_n(CpuRstN),
    .en_i (br_flush),
    .cnt_o(FlushCnt)
  );
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: stimulus pushes expected
// outputs into a scoreboard, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             CpuClk = 1'b0;
  logic             CpuRstN = 1'b0;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]       RegReadD;
  logic             MemToRegE, BranchE, JalrE, JalD, MulDivE, MdDone;
  logic [2:0]       RegWriteM, RegWriteW;
  logic             ICacheMiss, DCacheMiss;
  logic             StallF, StallD, StallE, StallM, StallW;
  logic             FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]       Forward1E, Forward2E;
  logic             MdStart;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CpuClk(CpuClk), .CpuRstN(CpuRstN),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegReadD(RegReadD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .MemToRegE(MemToRegE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
    .MulDivE(MulDivE), .MdDone(MdDone),
    .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .Forward1E(Forward1E), .Forward2E(Forward2E), .MdStart(MdStart),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CpuClk = ~CpuClk;

  typedef struct {
    string            name;
    logic [14:0]      outs;   // {stall F..W, flush F..W, MdStart, Fwd1, Fwd2}
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t             sb[$];
  int               tests_run = 0;
  int               tests_failed = 0;
  logic [CNT_W-1:0] sc_m = '0;
  logic [CNT_W-1:0] fc_m = '0;

  task automatic check(input string name, input logic [2*CNT_W-1:0] act,
                       input logic [2*CNT_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CpuClk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e.name,
              {{(2*CNT_W-15){1'b0}}, StallF, StallD, StallE, StallM, StallW,
               FlushF, FlushD, FlushE, FlushM, FlushW, MdStart, Forward1E, Forward2E},
              {{(2*CNT_W-15){1'b0}}, e.outs});
        check({e.name, "_cnt"}, {StallCnt, FlushCnt}, {e.sc, e.fc});
      end
    end
  end

  // Start a new cycle: after the edge, return every input to idle.
  task automatic step();
    @(posedge CpuClk);
    #1;
    CpuRstN = 1'b1;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegReadD = 0; MemToRegE = 0; RegWriteM = 0; RegWriteW = 0;
    BranchE = 0; JalrE = 0; JalD = 0; MulDivE = 0; MdDone = 0;
    ICacheMiss = 0; DCacheMiss = 0;
  endtask

  task automatic expect_v(input string name, input logic [4:0] st, input logic [4:0] fl,
                          input logic md, input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    if (!CpuRstN) begin
      sc_m = '0;
      fc_m = '0;
    end
    e.name = name;
    e.outs = {st, fl, md, f1, f2};
`ifdef HAZARD_PERF_CNT_EN
    e.sc = sc_m;
    e.fc = fc_m;
`else
    e.sc = '0;
    e.fc = '0;
`endif
    sb.push_back(e);
    if (CpuRstN) begin
      if (st[4]) sc_m = sc_m + 1;
      if ((BranchE || JalrE) && fl[2]) fc_m = fc_m + 1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); CpuRstN = 0;
    expect_v("reset", 5'b00000, 5'b11111, 0, 2'b00, 2'b00);
    step();
    expect_v("idle", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);

    step(); MemToRegE = 1; RdE = 5; Rs1D = 5; RegReadD = 2'b10;
    expect_v("load_use", 5'b11000, 5'b00100, 0, 2'b00, 2'b00);
    step(); Rs1E = 5; RdM = 5; RegWriteM = 3'b010;
    expect_v("fwd1_mem", 5'b00000, 5'b00000, 0, 2'b10, 2'b00);
    step(); Rs1E = 5; RdW = 5; RegWriteW = 3'b001;
    expect_v("fwd1_wb", 5'b00000, 5'b00000, 0, 2'b01, 2'b00);
    step(); RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs2E = 7;
    expect_v("fwd2_mem_prio", 5'b00000, 5'b00000, 0, 2'b00, 2'b10);
    step(); RdM = 0; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs2E = 7;
    expect_v("fwd2_wb_rdm_x0", 5'b00000, 5'b00000, 0, 2'b00, 2'b01);
    step(); RegWriteM = 1; RegWriteW = 1; MemToRegE = 1; RegReadD = 2'b11;
    expect_v("x0_no_hazard", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);
    step(); MemToRegE = 1; RdE = 5; Rs2D = 5; RegReadD = 2'b10;
    expect_v("lu_src_unused", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);
    step(); JalD = 1;
    expect_v("jal_d", 5'b00000, 5'b01000, 0, 2'b00, 2'b00);
    step(); BranchE = 1; MemToRegE = 1; RdE = 5; Rs1D = 5; RegReadD = 2'b10;
    expect_v("branch_over_lu", 5'b00000, 5'b01100, 0, 2'b00, 2'b00);
    step(); JalrE = 1;
    expect_v("jalr_e", 5'b00000, 5'b01100, 0, 2'b00, 2'b00);

    step(); MulDivE = 1;
    expect_v("md_start", 5'b11100, 5'b00010, 1, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(); MulDivE = 1;
      expect_v("md_busy", 5'b11100, 5'b00010, 0, 2'b00, 2'b00);
    end
    step(); MulDivE = 1; MdDone = 1;
    expect_v("md_done", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);
    step(); MdDone = 1;
    expect_v("md_done_in_run", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);

    step(); MulDivE = 1;
    expect_v("md2_start", 5'b11100, 5'b00010, 1, 2'b00, 2'b00);
    step(); MulDivE = 1;
    expect_v("md2_busy", 5'b11100, 5'b00010, 0, 2'b00, 2'b00);
    step(); MulDivE = 1; MdDone = 1; DCacheMiss = 1;
    expect_v("md2_done_miss", 5'b11111, 5'b00000, 0, 2'b00, 2'b00);
    for (int i = 0; i < 2; i++) begin
      step(); MulDivE = 1; DCacheMiss = 1;
      expect_v("md2_hold", 5'b11111, 5'b00000, 0, 2'b00, 2'b00);
    end
    step(); MulDivE = 1;
    expect_v("md2_release", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);
    step();
    expect_v("idle2", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);

    step(); ICacheMiss = 1; MulDivE = 1; BranchE = 1;
    expect_v("miss_priority", 5'b11111, 5'b00000, 0, 2'b00, 2'b00);
    step(); MulDivE = 1;
    expect_v("md3_start", 5'b11100, 5'b00010, 1, 2'b00, 2'b00);
    step(); MulDivE = 1;
    expect_v("md3_busy", 5'b11100, 5'b00010, 0, 2'b00, 2'b00);
    step(); MulDivE = 1; CpuRstN = 0; Rs1E = 5; RdM = 5; RegWriteM = 1;
    expect_v("reset_mid_md", 5'b00000, 5'b11111, 0, 2'b00, 2'b00);
    step(); MdDone = 1;
    expect_v("post_reset_run", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);
    step(); MulDivE = 1;
    expect_v("md4_start", 5'b11100, 5'b00010, 1, 2'b00, 2'b00);
    step(); MulDivE = 1; MdDone = 1;
    expect_v("md4_done_k1", 5'b00000, 5'b00000, 0, 2'b00, 2'b00);

    step();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CpuClk);
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush/forward controller for the five-stage RISC-V pipeline. It detects load-use and control hazards and selects EX-stage forwarding. It also sequences the multi-cycle multiply/divide unit in EX through a start/done handshake, holding the front of the pipeline while that unit is busy. It sits beside the pipeline registers and drives every Stall*/Flush* enable.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- CpuClk  in  1  pipeline clock
- CpuRstN  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  ID-stage source registers
- RegReadD  in  2  [1]=Rs1 used, [0]=Rs2 used (ID)
- Rs1E, Rs2E, RdE  in  5  EX-stage register fields
- MemToRegE  in  1  EX instruction is a load
- RdM, RdW  in  5  MEM/WB destinations
- RegWriteM, RegWriteW  in  3  write type; nonzero means the stage writes Rd
- BranchE, JalrE  in  1  taken branch / jalr resolved in EX
- JalD  in  1  jal decoded in ID
- MulDivE  in  1  EX instruction needs the multi-cycle mul/div unit
- MdDone  in  1  mul/div result valid (one-cycle pulse)
- ICacheMiss, DCacheMiss  in  1  cache miss, level until refill completes
- StallF, StallD, StallE, StallM, StallW  out  1  hold pipeline register
- FlushF, FlushD, FlushE, FlushM, FlushW  out  1  clear pipeline register to bubble
- Forward1E, Forward2E  out  2  00 regfile, 01 from WB, 10 from MEM
- MdStart  out  1  one-cycle start pulse to mul/div unit
- StallCnt, FlushCnt  out  CNT_W  performance counters

## Operation
- FSM states: RUN, MD_BUSY, MD_HOLD.
- RUN with MulDivE=1 and no cache miss: MdStart=1 for this cycle, StallF/D/E=1, FlushM=1, next state MD_BUSY.
- MD_BUSY, MdDone=0: StallF/D/E=1, FlushM=1.
- MD_BUSY, MdDone=1, no miss: release the stall this cycle and go to RUN.
- MD_BUSY, MdDone=1 during a cache miss: go to MD_HOLD.
- MD_HOLD: the result is retained and no new MdStart is issued. Once the miss clears, release the stall and go to RUN.
- Cache miss (ICacheMiss|DCacheMiss): all Stall*=1, all Flush*=0, MdStart=0. This has highest priority.
- Priority below cache miss:
  - mul/div stall
  - taken BranchE/JalrE: FlushD=1, FlushE=1, no stall; overrides load-use
  - load-use: StallF=1, StallD=1, FlushE=1
  - JalD: FlushD=1
- Load-use condition: MemToRegE & RdE≠0 & ((RegReadD[1] & RdE==Rs1D) | (RegReadD[0] & RdE==Rs2D)).
- Forwarding for Forward1E:
  - 10 if RegWriteM≠0 & RdM≠0 & RdM==Rs1E
  - else 01 if the same test holds on WB
  - else 00
  - MEM has priority over WB. Forward2E is identical using Rs2E.
- Register x0 is never a forwarding or hazard source.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the FSM state. They are valid in the same cycle.
- MdStart is asserted exactly once per mul/div instruction, in its first EX cycle.
- If MdDone arrives k cycles after MdStart, F/D/E stall for k cycles with no miss. The instruction advances on the MdDone edge.
- An MdDone in RUN state is ignored.
- Reset (CpuRstN=0, asynchronous):
  - state RUN
  - all Flush*=1
  - all Stall*=0
  - MdStart=0
  - Forward*=00
  - counters 0
- Reset mid-MD_BUSY aborts the sequence. The unit is not restarted after reset.

## Configuration
- HAZARD_PERF_CNT_EN defined: StallCnt increments each cycle StallF=1, and FlushCnt increments each cycle FlushE=1 due to BranchE/JalrE. Both saturate at all-ones and clear on reset.
- Undefined: no counter registers; StallCnt and FlushCnt are tied to 0.

## Structure
- Shared package hazard_pkg holds:
  - FSM state encoding (RUN=2'd0, MD_BUSY=2'd1, MD_HOLD=2'd2)
  - forward selects FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
- One sub-module, hazard_perf_cnt, a saturating CNT_W counter with enable. It is instantiated twice under the macro.

## Test plan
- Load x5 in EX, ID uses Rs1=x5 (RegReadD=10) -> StallF=StallD=FlushE=1 for one cycle. Next cycle Forward1E=01 or 10 per stage.
- RdM=RdW=x7, both writing, Rs2E=x7 -> Forward2E=10. RdM=x0 instead -> Forward2E=01.
- MulDivE=1, MdDone 4 cycles later -> one MdStart pulse and StallF/D/E high 4 cycles with FlushM=1. Released in the MdDone cycle.
- MdDone coincides with DCacheMiss lasting 3 cycles -> state MD_HOLD, all stalls 3 cycles, no second MdStart, then RUN.
- BranchE=1 together with the load-use condition -> FlushD=FlushE=1, StallF=0. With macro: FlushCnt=1.
- CpuRstN low during MD_BUSY -> immediately all Flush*=1, Stall*=0. After release, state RUN and counters 0.
